// File: rtl/arp_rx_parser.sv
// ARP receive parser: validates ARP frames addressed to this node
// and strobes the sender IP/MAC toward the ARP cache.
module arp_rx_parser #(
  parameter logic [31:0] LOCAL_IP  = {8'd192, 8'd168, 8'd0, 8'd2},
  parameter logic [47:0] LOCAL_MAC = 48'h00_0a_35_01_02_03
) (
  input  logic        sys_clk,
  input  logic        reset_n,
  input  logic        rx_en,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        store_en,
  output logic [31:0] store_ip,
  output logic [47:0] store_mac,
  output logic        arp_is_req,
  output logic        arp_is_reply
);

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    MATCH,
    EMIT,
    DROP
  } state_t;

  state_t      state;
  logic [5:0]  cnt;
  logic        bc_ok;
  logic        uc_ok;
  logic        oper_rep;
  logic [47:0] mac_sh;
  logic [31:0] ip_sh;

  logic        take;
  logic        byte_ok;
  logic        bc_nx;
  logic        uc_nx;
  logic [7:0]  mac_b;
  logic [7:0]  ip_b;

  // A byte is inspected only while the header is still being parsed
  assign take = rx_en & rx_valid & ((state == IDLE) | (state == HDR));

  // Expected LOCAL_MAC byte for the current destination-MAC index
  always_comb begin
    mac_b = 8'h00;
    case (cnt[2:0])
      3'd0: mac_b = LOCAL_MAC[47:40];
      3'd1: mac_b = LOCAL_MAC[39:32];
      3'd2: mac_b = LOCAL_MAC[31:24];
      3'd3: mac_b = LOCAL_MAC[23:16];
      3'd4: mac_b = LOCAL_MAC[15:8];
      3'd5: mac_b = LOCAL_MAC[7:0];
      default: mac_b = 8'h00;
    endcase
  end

  // Expected LOCAL_IP byte for the current target-IP index
  always_comb begin
    ip_b = 8'h00;
    case (cnt)
      6'd38: ip_b = LOCAL_IP[31:24];
      6'd39: ip_b = LOCAL_IP[23:16];
      6'd40: ip_b = LOCAL_IP[15:8];
      6'd41: ip_b = LOCAL_IP[7:0];
      default: ip_b = 8'h00;
    endcase
  end

  // Per-index field check; DA tracks broadcast and unicast separately
  always_comb begin
    bc_nx   = ((cnt == 6'd0) | bc_ok) & (rx_data == 8'hff);
    uc_nx   = ((cnt == 6'd0) | uc_ok) & (rx_data == mac_b);
    byte_ok = 1'b1;
    unique case (1'b1)
      (cnt <= 6'd5):  byte_ok = bc_nx | uc_nx;
      (cnt == 6'd12): byte_ok = (rx_data == 8'h08);
      (cnt == 6'd13): byte_ok = (rx_data == 8'h06);
      (cnt == 6'd14): byte_ok = (rx_data == 8'h00);
      (cnt == 6'd15): byte_ok = (rx_data == 8'h01);
      (cnt == 6'd16): byte_ok = (rx_data == 8'h08);
      (cnt == 6'd17): byte_ok = (rx_data == 8'h00);
      (cnt == 6'd18): byte_ok = (rx_data == 8'h06);
      (cnt == 6'd19): byte_ok = (rx_data == 8'h04);
      (cnt == 6'd20): byte_ok = (rx_data == 8'h00);
      (cnt == 6'd21): byte_ok = (rx_data == 8'h01) |
                                (rx_data == 8'h02);
      (cnt >= 6'd38 && cnt <= 6'd41):
                      byte_ok = (rx_data == ip_b);
      default:        byte_ok = 1'b1;
    endcase
  end

  // Frame FSM, byte counter, shadow capture and registered outputs
  always_ff @(posedge sys_clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= IDLE;
      cnt          <= '0;
      bc_ok        <= 1'b0;
      uc_ok        <= 1'b0;
      oper_rep     <= 1'b0;
      mac_sh       <= '0;
      ip_sh        <= '0;
      store_en     <= 1'b0;
      store_ip     <= '0;
      store_mac    <= '0;
      arp_is_req   <= 1'b0;
      arp_is_reply <= 1'b0;
    end else begin
      store_en     <= 1'b0;
      arp_is_req   <= 1'b0;
      arp_is_reply <= 1'b0;

      if (!rx_en) begin
        cnt <= '0;
      end else if (rx_valid && cnt != 6'd63) begin
        cnt <= cnt + 6'd1;
      end

      unique case (state)
        IDLE: if (rx_en) state <= HDR;
        HDR: if (!rx_en) state <= IDLE;
        MATCH: begin
          if (!rx_en) begin
            state        <= EMIT;
            store_en     <= 1'b1;
            store_ip     <= ip_sh;
            store_mac    <= mac_sh;
            arp_is_req   <= ~oper_rep;
            arp_is_reply <= oper_rep;
          end
        end
        EMIT: state <= IDLE;
        DROP: if (!rx_en) state <= IDLE;
        default: state <= IDLE;
      endcase

      if (take) begin
        if (cnt <= 6'd5) begin
          bc_ok <= bc_nx;
          uc_ok <= uc_nx;
        end
        if (cnt == 6'd21) begin
          oper_rep <= (rx_data == 8'h02);
        end
        if (cnt >= 6'd22 && cnt <= 6'd27) begin
          mac_sh <= {mac_sh[39:0], rx_data};
        end
        if (cnt >= 6'd28 && cnt <= 6'd31) begin
          ip_sh <= {ip_sh[23:0], rx_data};
        end
        if (!byte_ok) begin
          state <= DROP;
        end else if (cnt == 6'd41) begin
          state <= MATCH;
        end
      end
    end
  end

endmodule

// File: tb/tb_arp_rx_parser.sv
// Self-checking bench for arp_rx_parser: directed table, corner
// sequences and randomized frames against a frame-level model.
module tb_arp_rx_parser;

  localparam logic [31:0] LIP  = {8'd192, 8'd168, 8'd0, 8'd2};
  localparam logic [47:0] LMAC = 48'h00_0a_35_01_02_03;
  localparam logic [47:0] BC   = 48'hff_ff_ff_ff_ff_ff;

  logic        sys_clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        rx_en = 1'b0;
  logic        rx_valid = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        store_en;
  logic [31:0] store_ip;
  logic [47:0] store_mac;
  logic        arp_is_req;
  logic        arp_is_reply;

  int          errors = 0;
  int          checks = 0;
  int          pulses = 0;
  logic [31:0] exp_ip = '0;
  logic [47:0] exp_mac = '0;
  logic [7:0]  fq[$];

  typedef struct {
    logic [47:0] da;
    logic [15:0] etype;
    logic [15:0] oper;
    logic [47:0] sha;
    logic [31:0] spa;
    logic [31:0] tpa;
    int          len;
    bit          gaps;
    bit          e_en;
    bit          e_req;
    bit          e_rep;
    logic [31:0] e_ip;
    logic [47:0] e_mac;
  } vec_t;

  vec_t tbl[11];

  arp_rx_parser dut (
    .sys_clk      (sys_clk),
    .reset_n      (reset_n),
    .rx_en        (rx_en),
    .rx_valid     (rx_valid),
    .rx_data      (rx_data),
    .store_en     (store_en),
    .store_ip     (store_ip),
    .store_mac    (store_mac),
    .arp_is_req   (arp_is_req),
    .arp_is_reply (arp_is_reply)
  );

  always #5 sys_clk = ~sys_clk;

  always @(negedge sys_clk) begin
    if (store_en) pulses <= pulses + 1;
  end

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic build(input logic [47:0] da, input logic [15:0] et,
                       input logic [15:0] op, input logic [47:0] sha,
                       input logic [31:0] spa, input logic [31:0] tpa,
                       input int len);
    fq.delete();
    for (int i = 0; i < 6; i++) fq.push_back(da[47-8*i -: 8]);
    for (int i = 0; i < 6; i++) fq.push_back(8'h5a);
    fq.push_back(et[15:8]);
    fq.push_back(et[7:0]);
    fq.push_back(8'h00);
    fq.push_back(8'h01);
    fq.push_back(8'h08);
    fq.push_back(8'h00);
    fq.push_back(8'h06);
    fq.push_back(8'h04);
    fq.push_back(op[15:8]);
    fq.push_back(op[7:0]);
    for (int i = 0; i < 6; i++) fq.push_back(sha[47-8*i -: 8]);
    for (int i = 0; i < 4; i++) fq.push_back(spa[31-8*i -: 8]);
    for (int i = 0; i < 6; i++) fq.push_back(8'h00);
    for (int i = 0; i < 4; i++) fq.push_back(tpa[31-8*i -: 8]);
    while (fq.size() < len) fq.push_back(8'($urandom));
    while (fq.size() > len) void'(fq.pop_back());
  endtask

  // Whole-frame reference: decode fields from the byte array
  function automatic void model(output bit ok, output bit rep,
                                output logic [31:0] ip,
                                output logic [47:0] mac);
    logic [47:0] da;
    logic [31:0] tpa;
    logic [15:0] oper;
    ok = 1'b0;
    rep = 1'b0;
    ip = '0;
    mac = '0;
    da = '0;
    tpa = '0;
    if (fq.size() < 42) return;
    for (int i = 0; i < 6; i++) begin
      da  = {da[39:0], fq[i]};
      mac = {mac[39:0], fq[22+i]};
    end
    for (int i = 0; i < 4; i++) begin
      ip  = {ip[23:0], fq[28+i]};
      tpa = {tpa[23:0], fq[38+i]};
    end
    oper = {fq[20], fq[21]};
    ok = (da == BC || da == LMAC) &&
         {fq[12], fq[13]} == 16'h0806 &&
         {fq[14], fq[15]} == 16'h0001 &&
         {fq[16], fq[17]} == 16'h0800 &&
         fq[18] == 8'h06 && fq[19] == 8'h04 &&
         (oper == 16'd1 || oper == 16'd2) &&
         tpa == LIP;
    rep = (oper == 16'd2);
  endfunction

  task automatic send_byte(input logic [7:0] b, input bit gap);
    if (gap) begin
      rx_en = 1'b1;
      rx_valid = 1'b0;
      rx_data = 8'($urandom);
      @(posedge sys_clk); #1;
    end
    rx_en = 1'b1;
    rx_valid = 1'b1;
    rx_data = b;
    @(posedge sys_clk); #1;
  endtask

  task automatic do_frame(input string nm, input bit gaps,
                          input bit e_en, input bit e_req,
                          input bit e_rep, input logic [31:0] e_ip,
                          input logic [47:0] e_mac);
    int p0;
    p0 = pulses;
    foreach (fq[i]) send_byte(fq[i], gaps);
    rx_en = 1'b0;
    rx_valid = 1'b0;
    @(posedge sys_clk); #1;
    chk({nm, " store_en"}, 64'(store_en), 64'(e_en));
    chk({nm, " is_req"}, 64'(arp_is_req), 64'(e_req));
    chk({nm, " is_reply"}, 64'(arp_is_reply), 64'(e_rep));
    chk({nm, " store_ip"}, 64'(store_ip), 64'(e_ip));
    chk({nm, " store_mac"}, 64'(store_mac), 64'(e_mac));
    @(posedge sys_clk); #1;
    chk({nm, " store_en_drop"}, 64'(store_en), 64'd0);
    chk({nm, " pulse_count"}, 64'(pulses - p0), 64'(e_en));
    chk({nm, " ip_hold"}, 64'(store_ip), 64'(e_ip));
  endtask

  initial begin
    bit ok;
    bit rep;
    logic [31:0] mip;
    logic [47:0] mmac;
    int p0;

    tbl[0]  = '{BC, 16'h0806, 16'd1, 48'h112233445566, 32'hc0a8000a,
                LIP, 64, 1'b0, 1'b1, 1'b1, 1'b0,
                32'hc0a8000a, 48'h112233445566};
    tbl[1]  = '{LMAC, 16'h0806, 16'd2, 48'haabbccddeeff, 32'hc0a80014,
                LIP, 64, 1'b0, 1'b1, 1'b0, 1'b1,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[2]  = '{BC, 16'h0806, 16'd1, 48'h010101010101, 32'hc0a80033,
                32'hc0a80003, 64, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[3]  = '{BC, 16'h0800, 16'd1, 48'h010101010101, 32'hc0a80033,
                LIP, 64, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[4]  = '{48'h020000000001, 16'h0806, 16'd1, 48'h010101010101,
                32'hc0a80033, LIP, 64, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[5]  = '{BC, 16'h0806, 16'd3, 48'h010101010101, 32'hc0a80033,
                LIP, 64, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[6]  = '{BC, 16'h0806, 16'd1, 48'h010203040506, 32'hc0a80033,
                LIP, 30, 1'b0, 1'b0, 1'b0, 1'b0,
                32'hc0a80014, 48'haabbccddeeff};
    tbl[7]  = '{LMAC, 16'h0806, 16'd2, 48'h0a0b0c0d0e0f, 32'hc0a80063,
                LIP, 64, 1'b0, 1'b1, 1'b0, 1'b1,
                32'hc0a80063, 48'h0a0b0c0d0e0f};
    tbl[8]  = '{BC, 16'h0806, 16'd1, 48'h112233445566, 32'hc0a8000a,
                LIP, 64, 1'b1, 1'b1, 1'b1, 1'b0,
                32'hc0a8000a, 48'h112233445566};
    tbl[9]  = '{LMAC, 16'h0806, 16'd1, 48'h665544332211, 32'hc0a80050,
                LIP, 90, 1'b0, 1'b1, 1'b1, 1'b0,
                32'hc0a80050, 48'h665544332211};
    tbl[10] = '{BC, 16'h0806, 16'd2, 48'h123456789abc, 32'hc0a80001,
                LIP, 42, 1'b0, 1'b1, 1'b0, 1'b1,
                32'hc0a80001, 48'h123456789abc};

    repeat (2) @(posedge sys_clk);
    #1;
    chk("rst store_en", 64'(store_en), 64'd0);
    chk("rst is_req", 64'(arp_is_req), 64'd0);
    chk("rst is_reply", 64'(arp_is_reply), 64'd0);
    chk("rst store_ip", 64'(store_ip), 64'd0);
    chk("rst store_mac", 64'(store_mac), 64'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;

    for (int v = 0; v < 11; v++) begin
      build(tbl[v].da, tbl[v].etype, tbl[v].oper, tbl[v].sha,
            tbl[v].spa, tbl[v].tpa, tbl[v].len);
      do_frame($sformatf("vec%0d", v), tbl[v].gaps, tbl[v].e_en,
               tbl[v].e_req, tbl[v].e_rep, tbl[v].e_ip, tbl[v].e_mac);
      exp_ip = tbl[v].e_ip;
      exp_mac = tbl[v].e_mac;
    end

    build(BC, 16'h0806, 16'd1, 48'h112233445566, 32'hc0a8000a, LIP, 64);
    p0 = pulses;
    for (int i = 0; i < 25; i++) send_byte(fq[i], 1'b0);
    reset_n = 1'b0;
    rx_valid = 1'b0;
    #1;
    chk("midrst store_en", 64'(store_en), 64'd0);
    chk("midrst is_req", 64'(arp_is_req), 64'd0);
    chk("midrst store_ip", 64'(store_ip), 64'd0);
    chk("midrst store_mac", 64'(store_mac), 64'd0);
    @(negedge sys_clk);
    reset_n = 1'b1;
    @(posedge sys_clk); #1;
    for (int i = 25; i < fq.size(); i++) send_byte(fq[i], 1'b0);
    rx_en = 1'b0;
    rx_valid = 1'b0;
    repeat (2) begin
      @(posedge sys_clk); #1;
    end
    chk("midrst no_pulse", 64'(pulses - p0), 64'd0);
    chk("midrst ip_after", 64'(store_ip), 64'd0);
    chk("midrst mac_after", 64'(store_mac), 64'd0);
    build(tbl[1].da, tbl[1].etype, tbl[1].oper, tbl[1].sha,
          tbl[1].spa, tbl[1].tpa, tbl[1].len);
    do_frame("post_rst", 1'b0, 1'b1, 1'b0, 1'b1,
             32'hc0a80014, 48'haabbccddeeff);
    exp_ip = 32'hc0a80014;
    exp_mac = 48'haabbccddeeff;

    for (int k = 0; k < 40; k++) begin
      int r;
      int t;
      int idx;
      bit gaps;
      build(($urandom_range(1, 0) == 1) ? BC : LMAC, 16'h0806,
            16'($urandom_range(2, 1)), {16'($urandom), 32'($urandom)},
            {16'hc0a8, 16'($urandom)}, LIP, $urandom_range(80, 42));
      r = $urandom_range(5, 0);
      if (r < 2) begin
        idx = $urandom_range(41, 0);
        fq[idx] = fq[idx] ^ 8'($urandom_range(255, 1));
      end else if (r == 2) begin
        t = $urandom_range(41, 1);
        while (fq.size() > t) void'(fq.pop_back());
      end
      gaps = ($urandom_range(3, 0) == 0);
      model(ok, rep, mip, mmac);
      if (ok) begin
        exp_ip = mip;
        exp_mac = mmac;
      end
      do_frame($sformatf("rand%0d", k), gaps, ok, ok && !rep,
               ok && rep, exp_ip, exp_mac);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
